// File: rtl/tx_frame_arbiter_pkg.sv
// aes_top_pack: stream types, arbiter state encoding and round-robin helper
// shared by the transmit frame arbiter and its output register slice.
package aes_top_pack;

    localparam int MAC_STREAM_WIDTH = 32;
    localparam int MAC_EMPTY_WIDTH  = $clog2(MAC_STREAM_WIDTH / 8);
    localparam int TX_ARB_NUM_SRC   = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } tx_arb_state_t;

    typedef struct packed {
        logic [MAC_STREAM_WIDTH-1:0] data;
        logic                        sop;
        logic                        eop;
        logic [MAC_EMPTY_WIDTH-1:0]  empty;
    } st_beat_t;

    // On a tie the source that did not win last time goes next.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_skid.sv
// st_skid_buffer: generic 2-entry Avalon-ST register slice; out_* and
// in_ready_o are flop outputs so the sink's ready never reaches the source.
module st_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         pop, push;

    // The skid entry only fills when the output holds a beat the sink refused.
    always_comb begin
        pop        = !main_vld_q || out_ready_i;
        push       = in_valid_i && !skid_vld_q;
        main_vld_d = pop ? (skid_vld_q || push) : main_vld_q;
        main_d     = pop ? (skid_vld_q ? skid_q : in_data_i) : main_q;
        skid_vld_d = pop ? 1'b0 : (skid_vld_q || push);
        skid_d     = (!pop && push) ? in_data_i : skid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready_o  = !skid_vld_q;
    assign out_data_o  = main_q;
    assign out_valid_o = main_vld_q;

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-atomic round-robin arbiter of two Avalon-ST sources.
// Define TX_ARB_OUT_REG_EN to register the output through a 2-entry skid buffer.
module tx_frame_arbiter
    import aes_top_pack::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic                   in0_valid,
    input  logic                   in0_sop,
    input  logic                   in0_eop,
    input  logic [EMPTY_WIDTH-1:0] in0_empty,
    output logic                   in0_ready,
    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic                   in1_valid,
    input  logic                   in1_sop,
    input  logic                   in1_eop,
    input  logic [EMPTY_WIDTH-1:0] in1_empty,
    output logic                   in1_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    input  logic                   out_ready,
    output logic                   grant_id,
    output logic                   busy,
    output logic                   err_orphan
);

    localparam int BW = DATA_WIDTH + EMPTY_WIDTH + 2;

    tx_arb_state_t               state_q, state_d;
    logic                        last_q, last_d, grant_q, grant_d;
    logic [TX_ARB_NUM_SRC-1:0]   valid, sop, req, orphan;
    logic [BW-1:0]               beat [TX_ARB_NUM_SRC];
    logic [BW-1:0]               sel_beat, out_beat;
    logic                        idle, sel_valid, sel_ready, fire_eop;

    assign valid   = {in1_valid, in0_valid};
    assign sop     = {in1_sop, in0_sop};
    assign beat[0] = {in0_data, in0_sop, in0_eop, in0_empty};
    assign beat[1] = {in1_data, in1_sop, in1_eop, in1_empty};

    assign idle      = state_q == ARB_IDLE;
    assign req       = valid & sop;
    // Gated by rst_n so the discard path stays quiet while reset is held.
    assign orphan    = (idle && rst_n) ? (valid & ~sop) : '0;
    assign sel_beat  = beat[grant_q];
    assign sel_valid = !idle && valid[grant_q];
    assign fire_eop  = sel_valid && sel_ready && sel_beat[EMPTY_WIDTH];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        if (idle) begin
            if (|req) begin
                state_d = ARB_LOCKED;
                grant_d = rr_pick(req[0], req[1], last_q);
            end
        end else if (fire_eop) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

`ifdef TX_ARB_OUT_REG_EN
    st_skid_buffer #(.W(BW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (sel_beat),
        .in_valid_i  (sel_valid),
        .in_ready_o  (sel_ready),
        .out_data_o  (out_beat),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );
`else
    assign out_beat  = sel_beat;
    assign out_valid = sel_valid;
    assign sel_ready = out_ready;
`endif

    assign {out_data, out_sop, out_eop, out_empty} = out_beat;

    assign in0_ready  = idle ? orphan[0] : (!grant_q && sel_ready);
    assign in1_ready  = idle ? orphan[1] : (grant_q && sel_ready);
    assign grant_id   = grant_q;
    assign busy       = !idle;
    assign err_orphan = |orphan;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed scenarios for the transmit frame arbiter;
// timing expectations shift by one cycle when TX_ARB_OUT_REG_EN is defined.
module tb_tx_frame_arbiter;

`ifdef TX_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  e;
    } bt_t;

    typedef struct {
        bt_t b;
        int  c;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in0_data = '0, in1_data = '0, out_data;
    logic        in0_valid = 1'b0, in0_sop = 1'b0, in0_eop = 1'b0, in0_ready;
    logic        in1_valid = 1'b0, in1_sop = 1'b0, in1_eop = 1'b0, in1_ready;
    logic [1:0]  in0_empty = '0, in1_empty = '0, out_empty;
    logic        out_valid, out_sop, out_eop, out_ready = 1'b1;
    logic        grant_id, busy, err_orphan;

    bt_t  q0[$], q1[$];
    rec_t oq[$];
    int   cyc = 0, vecs = 0, errs = 0;
    logic s_ov, s_busy, s_gnt, s_err, s_r0, s_r1, s_or;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_data   (in0_data),
        .in0_valid  (in0_valid),
        .in0_sop    (in0_sop),
        .in0_eop    (in0_eop),
        .in0_empty  (in0_empty),
        .in0_ready  (in0_ready),
        .in1_data   (in1_data),
        .in1_valid  (in1_valid),
        .in1_sop    (in1_sop),
        .in1_eop    (in1_eop),
        .in1_empty  (in1_empty),
        .in1_ready  (in1_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_orphan (err_orphan)
    );

    task automatic frame(input int src, input logic [31:0] base, input int n, input logic [1:0] em);
        bt_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = base + 32'(i);
            b.sop = (i == 0);
            b.eop = (i == n - 1);
            b.e   = (i == n - 1) ? em : 2'd0;
            if (src == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic drive();
        bt_t h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        in0_valid = q0.size() > 0;
        in1_valid = q1.size() > 0;
        {in0_data, in0_sop, in0_eop, in0_empty} = h0;
        {in1_data, in1_sop, in1_eop, in1_empty} = h1;
    endtask

    // One clock: present source heads, sample at the falling edge, retire fired beats.
    task automatic step();
        logic f0, f1;
        rec_t r;
        drive();
        @(negedge clk);
        s_ov = out_valid; s_busy = busy; s_gnt = grant_id; s_err = err_orphan;
        s_r0 = in0_ready; s_r1 = in1_ready; s_or = out_ready;
        f0 = in0_valid && in0_ready;
        f1 = in1_valid && in1_ready;
        if (out_valid && out_ready) begin
            r.b = {out_data, out_sop, out_eop, out_empty};
            r.c = cyc;
            oq.push_back(r);
        end
        @(posedge clk);
        #1;
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
        cyc++;
        drive();
    endtask

    task automatic run_until(input int n, input int lim, input string tag);
        int k;
        k = 0;
        while (oq.size() < n && k < lim) begin
            step();
            k++;
        end
        vecs++;
        if (oq.size() < n) begin
            errs++;
            $display("FAIL %s_timeout: got %0d beats, need %0d", tag, oq.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        oq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        step(); step();
        vecs++; if (s_ov !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", s_ov); end
        vecs++; if (s_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", s_busy); end
        vecs++; if (s_gnt !== 1'b0) begin errs++; $display("FAIL reset_grant: got %b want 0", s_gnt); end
        vecs++; if (s_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", s_err); end
        vecs++; if ({s_r0, s_r1} !== 2'b00) begin errs++; $display("FAIL reset_ready: got %b want 00", {s_r0, s_r1}); end
        rst_n = 1'b1;
        step();
        oq.delete();
    endtask

    task automatic test_single();
        int   c0;
        logic bz[8];
        logic g1;
        bt_t  exp_b[4];
        exp_b[0] = {32'hA000_0000, 1'b1, 1'b0, 2'd0};
        exp_b[1] = {32'hA000_0001, 1'b0, 1'b0, 2'd0};
        exp_b[2] = {32'hA000_0002, 1'b0, 1'b0, 2'd0};
        exp_b[3] = {32'hA000_0003, 1'b0, 1'b1, 2'd2};
        oq.delete();
        c0 = cyc;
        frame(0, 32'hA000_0000, 4, 2'd2);
        g1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            bz[i] = s_busy;
            if (i == 0) begin
                vecs++; if (s_ov !== 1'b0) begin errs++; $display("FAIL single_bubble: got out_valid %b want 0", s_ov); end
            end
            if (i == 1) g1 = s_gnt;
        end
        vecs++; if (g1 !== 1'b0) begin errs++; $display("FAIL single_grant: got %b want 0", g1); end
        vecs++; if ({bz[0], bz[1], bz[4], bz[5]} !== 4'b0110) begin
            errs++; $display("FAIL single_busy: got %b want 0110", {bz[0], bz[1], bz[4], bz[5]});
        end
        vecs++; if (oq.size() != 4) begin errs++; $display("FAIL single_count: got %0d want 4", oq.size()); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= oq.size() || oq[i].b !== exp_b[i] || oq[i].c != c0 + 1 + LAT + i) begin
                errs++;
                $display("FAIL single_beat%0d: got %h @%0d want %h @%0d", i,
                         (i < oq.size()) ? oq[i].b : bt_t'('x), (i < oq.size()) ? oq[i].c : -1,
                         exp_b[i], c0 + 1 + LAT + i);
            end
        end
    endtask

    task automatic test_tie();
        logic [31:0] exp_d[8];
        exp_d = '{32'h0000_0100, 32'h0000_0101, 32'h1000_0100, 32'h1000_0101,
                  32'h0000_0200, 32'h0000_0201, 32'h1000_0200, 32'h1000_0201};
        do_reset();
        frame(0, 32'h0000_0100, 2, 2'd0);
        frame(0, 32'h0000_0200, 2, 2'd0);
        frame(1, 32'h1000_0100, 2, 2'd1);
        frame(1, 32'h1000_0200, 2, 2'd3);
        run_until(8, 40, "tie");
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (i >= oq.size() || oq[i].b.d !== exp_d[i]) begin
                errs++;
                $display("FAIL tie_order%0d: got %h want %h", i, (i < oq.size()) ? oq[i].b.d : 32'hx, exp_d[i]);
            end
        end
        step(); step();
    endtask

    task automatic test_contention();
        int          c0, fr, src, fi, b;
        logic [33:0] exp_v, got_v;
        oq.delete();
        c0 = cyc;
        for (int f = 0; f < 10; f++) begin
            frame(0, 32'h0A00_0000 + 32'(f * 16), 3, 2'd0);
            frame(1, 32'h0B00_0000 + 32'(f * 16), 3, 2'd0);
        end
        run_until(60, 200, "contention");
        vecs++; if (oq.size() != 60) begin errs++; $display("FAIL cont_count: got %0d want 60", oq.size()); end
        for (int k = 0; k < 60 && k < oq.size(); k++) begin
            fr = k / 3; src = fr % 2; fi = fr / 2; b = k % 3;
            exp_v = {(src != 0 ? 32'h0B00_0000 : 32'h0A00_0000) + 32'(fi * 16 + b), b == 0, b == 2};
            got_v = {oq[k].b.d, oq[k].b.sop, oq[k].b.eop};
            vecs++;
            if (got_v !== exp_v) begin errs++; $display("FAIL cont_beat%0d: got %h want %h", k, got_v, exp_v); end
        end
        if (oq.size() == 60) begin
            vecs++; if (oq[0].c != c0 + 1 + LAT) begin errs++; $display("FAIL cont_first: got %0d want %0d", oq[0].c, c0 + 1 + LAT); end
            vecs++; if (oq[59].c - oq[0].c != 78) begin errs++; $display("FAIL cont_span: got %0d want 78", oq[59].c - oq[0].c); end
        end
        step(); step();
    endtask

    task automatic test_backpressure();
        int  k;
        bt_t exp_b[6];
        exp_b[0] = {32'hC000_0000, 1'b1, 1'b0, 2'd0};
        exp_b[1] = {32'hC000_0001, 1'b0, 1'b0, 2'd0};
        exp_b[2] = {32'hC000_0002, 1'b0, 1'b0, 2'd0};
        exp_b[3] = {32'hC000_0003, 1'b0, 1'b1, 2'd1};
        exp_b[4] = {32'hD000_0000, 1'b1, 1'b0, 2'd0};
        exp_b[5] = {32'hD000_0001, 1'b0, 1'b1, 2'd2};
        oq.delete();
        frame(0, 32'hC000_0000, 4, 2'd1);
        frame(1, 32'hD000_0000, 2, 2'd2);
        k = 0;
        while (oq.size() < 6 && k < 60) begin
            out_ready = ~out_ready;
            step();
            k++;
            if (s_busy) begin
                vecs++;
                if ((s_gnt ? s_r0 : s_r1) !== 1'b0) begin errs++; $display("FAIL bp_other_ready: got 1 want 0 (grant %b)", s_gnt); end
`ifndef TX_ARB_OUT_REG_EN
                vecs++;
                if ((s_gnt ? s_r1 : s_r0) !== s_or) begin errs++; $display("FAIL bp_mirror: got %b want %b", s_gnt ? s_r1 : s_r0, s_or); end
`endif
            end
        end
        out_ready = 1'b1;
        step(); step(); step();
        vecs++; if (oq.size() != 6) begin errs++; $display("FAIL bp_count: got %0d want 6", oq.size()); end
        for (int i = 0; i < 6 && i < oq.size(); i++) begin
            vecs++;
            if (oq[i].b !== exp_b[i]) begin errs++; $display("FAIL bp_beat%0d: got %h want %h", i, oq[i].b, exp_b[i]); end
        end
    endtask

    task automatic test_orphan();
        oq.delete();
        out_ready = 1'b1;
        q1.push_back({32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0});
        frame(0, 32'hE000_0000, 2, 2'd0);
        step();
        vecs++; if ({s_err, s_r1, s_r0, s_busy} !== 4'b1100) begin
            errs++; $display("FAIL orphan_idle: got err/r1/r0/busy %b want 1100", {s_err, s_r1, s_r0, s_busy});
        end
        vecs++; if (q1.size() != 0) begin errs++; $display("FAIL orphan_consumed: got %0d left want 0", q1.size()); end
        step();
        vecs++; if ({s_err, s_busy, s_gnt} !== 3'b010) begin
            errs++; $display("FAIL orphan_grant: got err/busy/grant %b want 010", {s_err, s_busy, s_gnt});
        end
        run_until(2, 20, "orphan");
        step(); step();
        vecs++; if (oq.size() != 2) begin errs++; $display("FAIL orphan_count: got %0d want 2", oq.size()); end
        if (oq.size() == 2) begin
            vecs++;
            if ({oq[0].b.d, oq[1].b.d, oq[1].b.eop} !== {32'hE000_0000, 32'hE000_0001, 1'b1}) begin
                errs++; $display("FAIL orphan_data: got %h %h want e0000000 e0000001", oq[0].b.d, oq[1].b.d);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, errp, ovs;
        oq.delete();
        out_ready = 1'b1;
        frame(0, 32'h5000_0000, 5, 2'd3);
        k = 0;
        while (q0.size() > 4 && k < 10) begin
            step();
            k++;
        end
        rst_n = 1'b0;
        #1;
        vecs++; if ({out_valid, busy, in0_ready, err_orphan} !== 4'b0000) begin
            errs++; $display("FAIL rstmid_now: got valid/busy/rdy/err %b want 0000", {out_valid, busy, in0_ready, err_orphan});
        end
        step(); step();
        vecs++; if ({s_err, s_r0} !== 2'b00) begin errs++; $display("FAIL rstmid_held: got err/rdy %b want 00", {s_err, s_r0}); end
        rst_n = 1'b1;
        oq.delete();
        errp = 0; ovs = 0; k = 0;
        while (q0.size() > 0 && k < 10) begin
            step();
            errp += int'(s_err);
            ovs += int'(s_ov);
            k++;
        end
        vecs++; if (errp != 4) begin errs++; $display("FAIL rstmid_orphans: got %0d pulses want 4", errp); end
        vecs++; if (ovs != 0) begin errs++; $display("FAIL rstmid_leak: got %0d valid cycles want 0", ovs); end
        frame(0, 32'h6000_0000, 2, 2'd0);
        run_until(2, 20, "rstmid");
        step(); step();
        vecs++; if (oq.size() != 2) begin errs++; $display("FAIL rstmid_count: got %0d want 2", oq.size()); end
        if (oq.size() == 2) begin
            vecs++;
            if ({oq[0].b.d, oq[0].b.sop, oq[1].b.d, oq[1].b.eop} !== {32'h6000_0000, 1'b1, 32'h6000_0001, 1'b1}) begin
                errs++; $display("FAIL rstmid_frame: got %h %h want 60000000 60000001", oq[0].b.d, oq[1].b.d);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_tie();
        test_contention();
        test_backpressure();
        test_orphan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
